// File: rtl/platform_irq_pkg.sv
// Shared constants for the platform interrupt controller.
// Holds the register word addresses, bus widths, the VECTOR valid-bit position
// and the upper limit on the number of interrupt sources.
package platform_irq_pkg;

    localparam int unsigned DATA_W           = 16;
    localparam int unsigned ADDR_W           = 3;
    localparam int unsigned IDX_W            = 4;
    localparam int unsigned MAX_IRQ          = 15;
    localparam int unsigned VECTOR_VALID_BIT = 15;

    localparam logic [ADDR_W-1:0] ADDR_PENDING    = 3'd0;
    localparam logic [ADDR_W-1:0] ADDR_ENABLE     = 3'd1;
    localparam logic [ADDR_W-1:0] ADDR_EDGE       = 3'd2;
    localparam logic [ADDR_W-1:0] ADDR_VECTOR     = 3'd3;
    localparam logic [ADDR_W-1:0] ADDR_RAW        = 3'd4;
    localparam logic [ADDR_W-1:0] ADDR_ENABLE_SET = 3'd5;
    localparam logic [ADDR_W-1:0] ADDR_ENABLE_CLR = 3'd6;

endpackage

// File: rtl/platform_irq_ctrl_if.sv
// Avalon-MM slave bus of the interrupt controller.
//   address    word address (3 bits)
//   chipselect slave select
//   write_n    write strobe, active low
//   writedata  write data (16 bits)
//   readdata   registered read data (16 bits), driven by the slave
// Modports: master (CPU / bus fabric side), slave (controller side).
interface platform_irq_ctrl_if;

    logic [platform_irq_pkg::ADDR_W-1:0] address;
    logic                                chipselect;
    logic                                write_n;
    logic [platform_irq_pkg::DATA_W-1:0] writedata;
    logic [platform_irq_pkg::DATA_W-1:0] readdata;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata
    );

endinterface

// File: rtl/platform_irq_prio_enc.sv
// Fixed-priority encoder: the lowest set bit of req_i wins.
//   req_i   NUM_IRQ-bit request vector
//   valid_o any request set
//   idx_o   index of the lowest set bit (0 when none)
// Purely combinational.
module platform_irq_prio_enc
    import platform_irq_pkg::*;
#(
    parameter int unsigned NUM_IRQ = 8
) (
    input  logic [NUM_IRQ-1:0] req_i,
    output logic               valid_o,
    output logic [IDX_W-1:0]   idx_o
);

    always_comb begin
        valid_o = |req_i;
        idx_o   = '0;
        // Scan downwards so the last hit, the lowest index, is the one kept.
        for (int i = int'(NUM_IRQ) - 1; i >= 0; i--) begin
            if (req_i[i]) idx_o = IDX_W'(i);
        end
    end

endmodule

// File: rtl/platform_irq_ctrl.sv
// Platform interrupt controller: collects peripheral irq lines (timer on bit 0),
// latches edge-type sources, masks and prioritises them, and drives a single
// registered CPU interrupt plus a readable VECTOR register.
//   clk      system clock
//   reset_n  asynchronous reset, active low
//   bus      Avalon-MM slave (3-bit word address, 16-bit data, registered readdata)
//   irq_in   NUM_IRQ peripheral requests, active high
//   irq_out  CPU interrupt, active high, registered
// Optional macro IRQ_SYNC_EN: two-flop synchroniser on every irq_in bit, for
// sources outside the clk domain (adds two cycles of irq latency).
module platform_irq_ctrl
    import platform_irq_pkg::*;
#(
    parameter int unsigned          NUM_IRQ    = 8,   // 1..MAX_IRQ
    parameter logic [MAX_IRQ-1:0]   EDGE_RESET = '0
) (
    input  logic                clk,
    input  logic                reset_n,
    platform_irq_ctrl_if.slave  bus,
    input  logic [NUM_IRQ-1:0]  irq_in,
    output logic                irq_out
);

    logic [NUM_IRQ-1:0] in_s;        // sampled inputs (post-synchroniser)
    logic [NUM_IRQ-1:0] hist_q;      // in_s from the previous cycle
    logic [NUM_IRQ-1:0] pend_q, pend_d;
    logic [NUM_IRQ-1:0] en_q, en_d;
    logic [NUM_IRQ-1:0] edge_q, edge_d;
    logic [NUM_IRQ-1:0] wdata, w1c, rise, active;
    logic               wr;
    logic               vec_vld;
    logic [IDX_W-1:0]   vec_idx;
    logic [DATA_W-1:0]  vector;
    logic [DATA_W-1:0]  readdata_q, readdata_d;
    logic               irq_out_q;

    function automatic logic [DATA_W-1:0] zext(input logic [NUM_IRQ-1:0] v);
        zext              = '0;
        zext[NUM_IRQ-1:0] = v;
    endfunction

`ifdef IRQ_SYNC_EN
    logic [NUM_IRQ-1:0] sync1_q, sync2_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= irq_in;
            sync2_q <= sync1_q;
        end
    end

    assign in_s = sync2_q;
`else
    assign in_s = irq_in;
`endif

    assign wr    = bus.chipselect && !bus.write_n;
    assign wdata = bus.writedata[NUM_IRQ-1:0];
    assign w1c   = (wr && bus.address == ADDR_PENDING) ? wdata : '0;
    assign rise  = in_s & ~hist_q;

    // Level sources mirror the input; edge sources latch a rising edge and
    // clear on W1C, with a same-cycle edge taking precedence over the clear.
    assign pend_d = (~edge_q & in_s) | (edge_q & (rise | (pend_q & ~w1c)));
    assign active = pend_q & en_q;

    always_comb begin
        en_d   = en_q;
        edge_d = edge_q;
        if (wr) begin
            case (bus.address)
                ADDR_ENABLE:     en_d   = wdata;
                ADDR_EDGE:       edge_d = wdata;
                ADDR_ENABLE_SET: en_d   = en_q | wdata;
                ADDR_ENABLE_CLR: en_d   = en_q & ~wdata;
                default: ;
            endcase
        end
    end

    platform_irq_prio_enc #(.NUM_IRQ(NUM_IRQ)) u_prio (
        .req_i   (active),
        .valid_o (vec_vld),
        .idx_o   (vec_idx)
    );

    always_comb begin
        vector = '0;
        if (vec_vld) begin
            vector[VECTOR_VALID_BIT] = 1'b1;
            vector[IDX_W-1:0]        = vec_idx;
        end
    end

    // Read mux runs every cycle regardless of chipselect.
    always_comb begin
        readdata_d = '0;
        case (bus.address)
            ADDR_PENDING: readdata_d = zext(pend_q);
            ADDR_ENABLE:  readdata_d = zext(en_q);
            ADDR_EDGE:    readdata_d = zext(edge_q);
            ADDR_VECTOR:  readdata_d = vector;
            ADDR_RAW:     readdata_d = zext(in_s);
            default:      readdata_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hist_q     <= '0;
            pend_q     <= '0;
            en_q       <= '0;
            edge_q     <= EDGE_RESET[NUM_IRQ-1:0];
            readdata_q <= '0;
            irq_out_q  <= 1'b0;
        end else begin
            hist_q     <= in_s;
            pend_q     <= pend_d;
            en_q       <= en_d;
            edge_q     <= edge_d;
            readdata_q <= readdata_d;
            irq_out_q  <= |active;
        end
    end

    assign bus.readdata = readdata_q;
    assign irq_out      = irq_out_q;

endmodule

// File: tb/tb_platform_irq_ctrl.sv
// Self-checking bench for platform_irq_ctrl: directed scenarios plus a
// randomized phase, all compared against a cycle-level behavioural model.
module tb_platform_irq_ctrl;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [N-1:0] irq_in;
    logic         irq_out;

    platform_irq_ctrl_if bus();

    platform_irq_ctrl #(.NUM_IRQ(N), .EDGE_RESET('0)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus),
        .irq_in  (irq_in),
        .irq_out (irq_out)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [N-1:0] m_pend, m_en, m_edge, m_prev, m_s1, m_s2;
    logic [15:0]  m_rd;
    logic         m_irq;

    task automatic model_reset();
        m_pend = '0; m_en = '0; m_edge = '0; m_prev = '0;
        m_s1 = '0; m_s2 = '0; m_rd = '0; m_irq = 1'b0;
    endtask

    // One clock edge: outputs come from the state held before the edge.
    task automatic model_step();
        logic [N-1:0] seen, act, wd, np;
        logic [15:0]  vec;
        logic         wr;
`ifdef IRQ_SYNC_EN
        seen = m_s2;
`else
        seen = irq_in;
`endif
        wr  = bus.chipselect && !bus.write_n;
        wd  = bus.writedata[N-1:0];
        act = m_pend & m_en;
        vec = 16'h0;
        for (int i = N - 1; i >= 0; i--)
            if (act[i]) vec = 16'h8000 + 16'(i);
        case (bus.address)
            3'd0: m_rd = {8'h0, m_pend};
            3'd1: m_rd = {8'h0, m_en};
            3'd2: m_rd = {8'h0, m_edge};
            3'd3: m_rd = vec;
            3'd4: m_rd = {8'h0, seen};
            default: m_rd = 16'h0;
        endcase
        m_irq = (act != 0);
        for (int i = 0; i < N; i++) begin
            if (!m_edge[i])                        np[i] = seen[i];
            else if (seen[i] && !m_prev[i])        np[i] = 1'b1;
            else if (wr && bus.address == 3'd0 && wd[i]) np[i] = 1'b0;
            else                                   np[i] = m_pend[i];
        end
        m_pend = np;
        m_prev = seen;
        if (wr) begin
            if (bus.address == 3'd1) m_en = wd;
            if (bus.address == 3'd2) m_edge = wd;
            if (bus.address == 3'd5) m_en = m_en | wd;
            if (bus.address == 3'd6) m_en = m_en & ~wd;
        end
        m_s2 = m_s1;
        m_s1 = irq_in;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check("readdata", {16'h0, bus.readdata}, {16'h0, m_rd});
        check("irq_out", {31'h0, irq_out}, {31'h0, m_irq});
    endtask

    task automatic idle();
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [15:0] d);
        bus.address = a; bus.writedata = d;
        bus.chipselect = 1'b1; bus.write_n = 1'b0;
        tick();
        idle();
    endtask

    task automatic rd(input logic [2:0] a);
        bus.address = a; bus.chipselect = 1'b1; bus.write_n = 1'b1;
        tick();
        idle();
    endtask

    initial begin
        reset_n = 1'b0;
        irq_in  = '0;
        bus.address = '0; bus.writedata = '0;
        idle();
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_readdata", {16'h0, bus.readdata}, 32'h0);
        check("rst_irq_out", {31'h0, irq_out}, 32'h0);
        reset_n = 1'b1;

        // every address reads zero after reset
        for (int a = 0; a < 8; a++) begin
            rd(3'(a));
            check("rst_read", {16'h0, bus.readdata}, 32'h0);
        end

`ifndef IRQ_SYNC_EN
        // level source 0
        wr(3'd1, 16'h0001);
        irq_in = 8'h01;
        rd(3'd0);
        rd(3'd0);
        check("lvl_pending", {16'h0, bus.readdata}, 32'h0001);
        check("lvl_irq_rise", {31'h0, irq_out}, 32'h1);
        rd(3'd3);
        check("lvl_vector", {16'h0, bus.readdata}, 32'h8000);
        irq_in = 8'h00;
        tick();
        check("lvl_irq_hold", {31'h0, irq_out}, 32'h1);
        tick();
        check("lvl_irq_fall", {31'h0, irq_out}, 32'h0);

        // edge source 1: pulse latches, W1C clears
        wr(3'd2, 16'h0002);
        wr(3'd1, 16'h0002);
        irq_in = 8'h02;
        tick();
        irq_in = 8'h00;
        rd(3'd0);
        check("edge_latched", {16'h0, bus.readdata}, 32'h0002);
        rd(3'd3);
        check("edge_vector", {16'h0, bus.readdata}, 32'h8001);
        wr(3'd0, 16'h0002);
        tick();
        check("edge_w1c_irq", {31'h0, irq_out}, 32'h0);
        rd(3'd0);
        check("edge_w1c_pend", {16'h0, bus.readdata}, 32'h0);

        // set beats clear; held-high source does not re-pend
        irq_in = 8'h02;
        tick();
        irq_in = 8'h00;
        tick();
        irq_in = 8'h02;
        wr(3'd0, 16'h0002);
        rd(3'd0);
        check("set_wins", {16'h0, bus.readdata}, 32'h0002);
        wr(3'd0, 16'h0002);
        tick();
        rd(3'd0);
        check("no_repend", {16'h0, bus.readdata}, 32'h0);
        irq_in = 8'h00;

        // priority and enable set/clear
        wr(3'd2, 16'h0000);
        irq_in = 8'h0C;
        wr(3'd1, 16'h0008);
        tick();
        rd(3'd3);
        check("prio_v3", {16'h0, bus.readdata}, 32'h8003);
        wr(3'd5, 16'h0004);
        rd(3'd3);
        check("prio_v2", {16'h0, bus.readdata}, 32'h8002);
        wr(3'd6, 16'h000C);
        tick();
        check("enclr_irq", {31'h0, irq_out}, 32'h0);
        rd(3'd3);
        check("enclr_vec", {16'h0, bus.readdata}, 32'h0);
        irq_in = 8'h00;
`else
        wr(3'd1, 16'h0001);
        irq_in = 8'h01;
        repeat (3) tick();
        check("sync_irq_early", {31'h0, irq_out}, 32'h0);
        tick();
        check("sync_irq_rise", {31'h0, irq_out}, 32'h1);
`endif

        // reset while an interrupt is pending clears everything at once
        wr(3'd1, 16'h00FF);
        irq_in = 8'h01;
        bus.address = 3'd0;
        repeat (5) tick();
        check("pre_rst_irq", {31'h0, irq_out}, 32'h1);
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_irq", {31'h0, irq_out}, 32'h0);
        check("async_rst_rd", {16'h0, bus.readdata}, 32'h0);
        model_reset();
        irq_in = 8'h00;
        @(negedge clk);
        reset_n = 1'b1;
        rd(3'd0);
        check("post_rst_pend", {16'h0, bus.readdata}, 32'h0);

        // randomized traffic
        for (int c = 0; c < 600; c++) begin
            irq_in = irq_in ^ (8'($urandom) & 8'($urandom));
            case ($urandom_range(0, 3))
                0: idle();
                1: begin
                    bus.address = 3'($urandom); bus.chipselect = 1'b1; bus.write_n = 1'b1;
                end
                2: begin
                    bus.address = 3'($urandom); bus.writedata = 16'($urandom);
                    bus.chipselect = 1'b1; bus.write_n = 1'b0;
                end
                default: begin
                    bus.address = 3'($urandom); bus.writedata = 16'($urandom);
                    bus.chipselect = 1'b0; bus.write_n = 1'b0;
                end
            endcase
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
